s2_multiplexer: RTL and testbench



---
 rtl/s2_multiplexer_pkg.sv | 16 +
 rtl/s2_multiplexer.sv | 89 ++++++++
 tb/tb_s2_multiplexer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/s2_multiplexer_pkg.sv
// -----------------------------------------------------------------------------
// s2_multiplexer_pkg
// Shared constants for the tinyGPU S2 source-select multiplexer:
//   - S2 select-code encodings driven by the control unit
//   - default datapath word width
// -----------------------------------------------------------------------------
package s2_multiplexer_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] SEL_IN0     = 2'b00;
    localparam logic [1:0] SEL_IN1     = 2'b01;
    localparam logic [1:0] SEL_IN2     = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

endpackage : s2_multiplexer_pkg

// File: rtl/s2_multiplexer.sv
// -----------------------------------------------------------------------------
// s2_multiplexer
// Three-input word-wide source-select multiplexer steered by the 2-bit S2
// control field. The unused code 2'b11 drives an all-zero word and raises
// sel_err so control-unit bugs are visible.
//
// Parameters:
//   WIDTH   - width of each input bus and of d_out
//   OUT_REG - 1: registered output (one-cycle latency), 0: combinational
//
// Ports:
//   clock   - system clock, rising-edge active
//   reset   - synchronous, active-high; forces d_out/sel_err to 0
//   in0     - source 0, selected by s2 = 2'b00
//   in1     - source 1, selected by s2 = 2'b01
//   in2     - source 2, selected by s2 = 2'b10
//   s2      - select code
//   d_out   - selected data word
//   sel_err - high while the selected code is the illegal 2'b11
// -----------------------------------------------------------------------------
module s2_multiplexer
    import s2_multiplexer_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       s2,
    output logic [WIDTH-1:0] d_out,
    output logic             sel_err
);

    // Full decode: every 2-state code has an explicit arm, so no X and no latch.
    function automatic logic [WIDTH-1:0] decode_sel(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] a0,
        input logic [WIDTH-1:0] a1,
        input logic [WIDTH-1:0] a2
    );
        logic [WIDTH-1:0] res;
        res = '0;
        case (sel)
            SEL_IN0:     res = a0;
            SEL_IN1:     res = a1;
            SEL_IN2:     res = a2;
            SEL_ILLEGAL: res = '0;
            default:     res = '0;
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0] d_out_d;
    logic             sel_err_d;

    always_comb begin
        d_out_d   = decode_sel(s2, in0, in1, in2);
        sel_err_d = (s2 == SEL_ILLEGAL);
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [WIDTH-1:0] d_out_q;
            logic             sel_err_q;

            // Reset takes priority over the decode at the same edge.
            always_ff @(posedge clock) begin
                if (reset) begin
                    d_out_q   <= '0;
                    sel_err_q <= 1'b0;
                end else begin
                    d_out_q   <= d_out_d;
                    sel_err_q <= sel_err_d;
                end
            end

            assign d_out   = d_out_q;
            assign sel_err = sel_err_q;
        end else begin : g_comb
            // No state here; reset simply gates the outputs to zero.
            assign d_out   = reset ? '0   : d_out_d;
            assign sel_err = reset ? 1'b0 : sel_err_d;
        end
    endgenerate

endmodule : s2_multiplexer

// File: tb/tb_s2_multiplexer.sv
// -----------------------------------------------------------------------------
// tb_s2_multiplexer
// Drives one directed vector per cycle into a registered and a combinational
// build of s2_multiplexer sharing the same inputs. Each vector carries its
// hand-computed expected output; it is queued for the registered build
// (checked after the next rising edge) and for the combinational build
// (checked immediately). The registered build is also checked to still hold
// its previous value before the edge, which pins its latency to one cycle.
// -----------------------------------------------------------------------------
module tb_s2_multiplexer;

    typedef struct {
        logic [15:0] exp_d;
        logic        exp_err;
    } exp_t;

    typedef struct {
        logic [15:0] exp_d;
        logic        exp_err;
        logic [15:0] prev_d;
        logic        prev_err;
        logic        prev_vld;
    } comb_exp_t;

    logic        clock;
    logic        reset;
    logic [15:0] in0, in1, in2;
    logic [1:0]  s2;
    logic [15:0] d_out_r, d_out_c;
    logic        sel_err_r, sel_err_c;

    int checks   = 0;
    int failures = 0;

    exp_t      reg_q[$];
    comb_exp_t comb_q[$];
    event      comb_ev;

    logic [15:0] last_d;
    logic        last_err;
    logic        last_vld;

    s2_multiplexer #(.WIDTH(16), .OUT_REG(1'b1)) dut_reg (
        .clock  (clock),
        .reset  (reset),
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .s2     (s2),
        .d_out  (d_out_r),
        .sel_err(sel_err_r)
    );

    s2_multiplexer #(.WIDTH(16), .OUT_REG(1'b0)) dut_comb (
        .clock  (clock),
        .reset  (reset),
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .s2     (s2),
        .d_out  (d_out_c),
        .sel_err(sel_err_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered-build monitor: one expectation per rising edge.
    always begin
        @(posedge clock);
        #1;
        if (reg_q.size() > 0) begin
            exp_t e;
            e = reg_q.pop_front();
            checks++;
            if (d_out_r !== e.exp_d || sel_err_r !== e.exp_err) begin
                failures++;
                $display("FAIL reg_out: got d_out=%h sel_err=%b, expected d_out=%h sel_err=%b",
                         d_out_r, sel_err_r, e.exp_d, e.exp_err);
            end
        end
    end

    // Combinational-build monitor plus pre-edge hold check on the registered build.
    always begin
        @(comb_ev);
        #1;
        if (comb_q.size() > 0) begin
            comb_exp_t c;
            c = comb_q.pop_front();
            checks++;
            if (d_out_c !== c.exp_d || sel_err_c !== c.exp_err) begin
                failures++;
                $display("FAIL comb_out: got d_out=%h sel_err=%b, expected d_out=%h sel_err=%b",
                         d_out_c, sel_err_c, c.exp_d, c.exp_err);
            end
            if (c.prev_vld) begin
                checks++;
                if (d_out_r !== c.prev_d || sel_err_r !== c.prev_err) begin
                    failures++;
                    $display("FAIL reg_hold: got d_out=%h sel_err=%b, expected d_out=%h sel_err=%b",
                             d_out_r, sel_err_r, c.prev_d, c.prev_err);
                end
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] s,
                        input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                        input logic [15:0] ed, input logic ee);
        exp_t      e;
        comb_exp_t c;
        @(negedge clock);
        reset = r;
        s2    = s;
        in0   = a0;
        in1   = a1;
        in2   = a2;
        e.exp_d   = ed;
        e.exp_err = ee;
        reg_q.push_back(e);
        c.exp_d    = ed;
        c.exp_err  = ee;
        c.prev_d   = last_d;
        c.prev_err = last_err;
        c.prev_vld = last_vld;
        comb_q.push_back(c);
        -> comb_ev;
        last_d   = ed;
        last_err = ee;
        last_vld = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        s2       = 2'b01;
        in0      = 16'h0000;
        in1      = 16'h0001;
        in2      = 16'h0002;
        last_d   = '0;
        last_err = 1'b0;
        last_vld = 1'b0;

        //   rst  s2     in0      in1      in2      exp_d    exp_err
        // Reset held for two edges, then release
        step(1, 2'b01, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 0);
        step(1, 2'b01, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 0);
        step(0, 2'b01, 16'h0000, 16'h0001, 16'h0002, 16'h0001, 0);
        // Select sweep
        step(0, 2'b00, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 0);
        step(0, 2'b01, 16'h0000, 16'h0001, 16'h0002, 16'h0001, 0);
        step(0, 2'b10, 16'h0000, 16'h0001, 16'h0002, 16'h0002, 0);
        // Illegal select and recovery
        step(0, 2'b11, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 1);
        step(0, 2'b00, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 0);
        // Data tracking on in2; in0/in1 changes must not leak through
        step(0, 2'b10, 16'h0000, 16'h0001, 16'h0002, 16'h0002, 0);
        step(0, 2'b10, 16'h1111, 16'h0001, 16'hBEEF, 16'hBEEF, 0);
        step(0, 2'b10, 16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF, 0);
        // Mid-run reset pulse
        step(0, 2'b01, 16'h1111, 16'hA5A5, 16'hFFFF, 16'hA5A5, 0);
        step(0, 2'b01, 16'h1111, 16'hA5A5, 16'hFFFF, 16'hA5A5, 0);
        step(1, 2'b01, 16'h1111, 16'hA5A5, 16'hFFFF, 16'h0000, 0);
        step(0, 2'b01, 16'h1111, 16'hA5A5, 16'hFFFF, 16'hA5A5, 0);
        // in2 = 0x1234, then reset forces zero
        step(0, 2'b10, 16'h1111, 16'hA5A5, 16'h1234, 16'h1234, 0);
        step(1, 2'b10, 16'h1111, 16'hA5A5, 16'h1234, 16'h0000, 0);
        // Illegal code with all-ones on in0; reset must also mask sel_err
        step(0, 2'b11, 16'hFFFF, 16'hA5A5, 16'h1234, 16'h0000, 1);
        step(1, 2'b11, 16'hFFFF, 16'hA5A5, 16'h1234, 16'h0000, 0);
        step(0, 2'b00, 16'h8001, 16'hA5A5, 16'h1234, 16'h8001, 0);

        @(posedge clock);
        #3;
        checks++;
        if (reg_q.size() != 0 || comb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got reg_q=%0d comb_q=%0d pending, expected 0 and 0",
                     reg_q.size(), comb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_s2_multiplexer
